// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - one-at-a-time issue/complete sequencer for the signed and unsigned divider IPs
//
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-high reset (shared with the IPs)
//   req_valid/req_ready        EX request handshake; req_ready is high only when idle
//   req_signed, req_mod        signed/unsigned unit select, remainder/quotient select
//   req_src1, req_src2         dividend, divisor
//   flush                      cancel the current operation
//   res_valid/res_data         held result, released on res_ready
//   busy                       controller is not idle
//   s_*/u_* tvalid, tready     dividend and divisor channels of the signed/unsigned IP
//   div_dividend_tdata,
//   div_divisor_tdata          latched operands, shared by both IPs
//   s_/u_dout_tvalid, _tdata   IP results: quotient [63:32], remainder [31:0]
module div_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic        req_mod,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        req_ready,
    input  logic        flush,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready,
    output logic        busy,
    output logic        s_dividend_tvalid,
    output logic        s_divisor_tvalid,
    output logic        u_dividend_tvalid,
    output logic        u_divisor_tvalid,
    input  logic        s_dividend_tready,
    input  logic        s_divisor_tready,
    input  logic        u_dividend_tready,
    input  logic        u_divisor_tready,
    output logic [31:0] div_dividend_tdata,
    output logic [31:0] div_divisor_tdata,
    input  logic        s_dout_tvalid,
    input  logic [63:0] s_dout_tdata,
    input  logic        u_dout_tvalid,
    input  logic [63:0] u_dout_tdata
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

    state_t      state;
    logic        op_signed;
    logic        op_mod;
    logic        dd_acc;
    logic        dv_acc;
    // Flush arrived while one operand was already taken: finish the pair, then drain.
    logic        cancel;

    logic        dd_tvalid;
    logic        dv_tvalid;
    logic        dd_tready;
    logic        dv_tready;
    logic        dd_hs;
    logic        dv_hs;
    logic        dd_done;
    logic        dv_done;
    logic        dout_tvalid;
    logic [63:0] dout_tdata;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    assign dd_tvalid = (state == ISSUE) && !dd_acc;
    assign dv_tvalid = (state == ISSUE) && !dv_acc;

    assign s_dividend_tvalid = dd_tvalid &&  op_signed;
    assign u_dividend_tvalid = dd_tvalid && !op_signed;
    assign s_divisor_tvalid  = dv_tvalid &&  op_signed;
    assign u_divisor_tvalid  = dv_tvalid && !op_signed;

    assign dd_tready = op_signed ? s_dividend_tready : u_dividend_tready;
    assign dv_tready = op_signed ? s_divisor_tready  : u_divisor_tready;

    assign dd_hs   = dd_tvalid && dd_tready;
    assign dv_hs   = dv_tvalid && dv_tready;
    // A channel counts as delivered if it completed earlier or completes this cycle.
    assign dd_done = dd_acc || dd_hs;
    assign dv_done = dv_acc || dv_hs;

    // Only the unit that was issued to can deliver our result.
    assign dout_tvalid = op_signed ? s_dout_tvalid : u_dout_tvalid;
    assign dout_tdata  = op_signed ? s_dout_tdata  : u_dout_tdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            op_signed          <= 1'b0;
            op_mod             <= 1'b0;
            dd_acc             <= 1'b0;
            dv_acc             <= 1'b0;
            cancel             <= 1'b0;
            res_data           <= 32'h0;
            div_dividend_tdata <= 32'h0;
            div_divisor_tdata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && !flush) begin
                        op_signed          <= req_signed;
                        op_mod             <= req_mod;
                        div_dividend_tdata <= req_src1;
                        div_divisor_tdata  <= req_src2;
                        dd_acc             <= 1'b0;
                        dv_acc             <= 1'b0;
                        cancel             <= 1'b0;
                        state              <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dd_hs) dd_acc <= 1'b1;
                    if (dv_hs) dv_acc <= 1'b1;
                    if (flush && !dd_done && !dv_done) begin
                        // Nothing reached the IP yet: abandon without a drain.
                        state <= IDLE;
                    end else if (dd_done && dv_done) begin
                        state <= (cancel || flush) ? DRAIN : WAIT;
                    end else if (flush) begin
                        cancel <= 1'b1;
                    end
                end
                WAIT: begin
                    if (dout_tvalid) begin
                        if (flush) begin
                            // Result lands in the flush cycle: it is dropped here.
                            state <= IDLE;
                        end else begin
                            res_data <= op_mod ? dout_tdata[31:0] : dout_tdata[63:32];
                            state    <= DONE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: begin
                    if (flush || res_ready) state <= IDLE;
                end
                DRAIN: begin
                    if (dout_tvalid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - self-checking bench for div_issue_ctrl with divider IP models
module tb_div_issue_ctrl;

    localparam int IP_LAT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_signed = 1'b0;
    logic        req_mod = 1'b0;
    logic [31:0] req_src1 = 32'h0;
    logic [31:0] req_src2 = 32'h0;
    logic        req_ready;
    logic        flush = 1'b0;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready = 1'b0;
    logic        busy;
    logic        s_dividend_tvalid, s_divisor_tvalid, u_dividend_tvalid, u_divisor_tvalid;
    logic        dd_tready = 1'b1;
    logic        dv_tready = 1'b1;
    logic [31:0] div_dividend_tdata, div_divisor_tdata;
    logic        s_dout_tvalid = 1'b0;
    logic        u_dout_tvalid = 1'b0;
    logic [63:0] s_dout_tdata = 64'h0;
    logic [63:0] u_dout_tdata = 64'h0;
    logic        stray_u = 1'b0;

    int checks = 0;
    int errors = 0;

    div_issue_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_signed(req_signed), .req_mod(req_mod),
        .req_src1(req_src1), .req_src2(req_src2), .req_ready(req_ready),
        .flush(flush), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
        .busy(busy),
        .s_dividend_tvalid(s_dividend_tvalid), .s_divisor_tvalid(s_divisor_tvalid),
        .u_dividend_tvalid(u_dividend_tvalid), .u_divisor_tvalid(u_divisor_tvalid),
        .s_dividend_tready(dd_tready), .s_divisor_tready(dv_tready),
        .u_dividend_tready(dd_tready), .u_divisor_tready(dv_tready),
        .div_dividend_tdata(div_dividend_tdata), .div_divisor_tdata(div_divisor_tdata),
        .s_dout_tvalid(s_dout_tvalid), .s_dout_tdata(s_dout_tdata),
        .u_dout_tvalid(u_dout_tvalid), .u_dout_tdata(u_dout_tdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] div_ref(input logic sg, input logic md,
                                            input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (sg) begin
            if (md) return sa % sb;
            return sa / sb;
        end
        if (md) return a % b;
        return a / b;
    endfunction

    // Behavioural model: what one outstanding request must look like from outside.
    logic        m_idle = 1'b1, m_rv = 1'b0, m_cancel = 1'b0;
    logic        m_dd_need = 1'b0, m_dv_need = 1'b0;
    logic        m_sg = 1'b0, m_md = 1'b0;
    logic [31:0] m_a = 0, m_b = 0, m_rd = 0;
    int          m_acc_cnt = 0, rv_cnt = 0, s_tv_cnt = 0, dd_tv_cnt = 0, dv_tv_cnt = 0;

    // Divider IP models: collect an operand pair, answer IP_LAT+1 cycles later.
    logic        s_dd_v = 0, s_dv_v = 0, u_dd_v = 0, u_dv_v = 0;
    logic [31:0] s_dd = 0, s_dv = 0, u_dd = 0, u_dv = 0;
    int          s_cnt = 0, u_cnt = 0;
    logic [63:0] s_res = 0, u_res = 0;

    task automatic ip_drive();
        s_dout_tvalid = 1'b0;
        u_dout_tvalid = stray_u;
        u_dout_tdata  = stray_u ? 64'hDEADBEEF_CAFEF00D : 64'h0;
        if (reset) begin
            s_cnt = 0; u_cnt = 0;
            s_dd_v = 0; s_dv_v = 0; u_dd_v = 0; u_dv_v = 0;
        end else begin
            if (s_cnt > 0) begin
                s_cnt--;
                if (s_cnt == 0) begin s_dout_tvalid = 1'b1; s_dout_tdata = s_res; end
            end
            if (u_cnt > 0) begin
                u_cnt--;
                if (u_cnt == 0) begin u_dout_tvalid = 1'b1; u_dout_tdata = u_res; end
            end
        end
    endtask

    task automatic ip_collect();
        if (s_dividend_tvalid && dd_tready) begin s_dd_v = 1; s_dd = div_dividend_tdata; end
        if (s_divisor_tvalid  && dv_tready) begin s_dv_v = 1; s_dv = div_divisor_tdata;  end
        if (u_dividend_tvalid && dd_tready) begin u_dd_v = 1; u_dd = div_dividend_tdata; end
        if (u_divisor_tvalid  && dv_tready) begin u_dv_v = 1; u_dv = div_divisor_tdata;  end
        if (s_dd_v && s_dv_v) begin
            s_res = {div_ref(1'b1, 1'b0, s_dd, s_dv), div_ref(1'b1, 1'b1, s_dd, s_dv)};
            s_cnt = IP_LAT + 1; s_dd_v = 0; s_dv_v = 0;
        end
        if (u_dd_v && u_dv_v) begin
            u_res = {div_ref(1'b0, 1'b0, u_dd, u_dv), div_ref(1'b0, 1'b1, u_dd, u_dv)};
            u_cnt = IP_LAT + 1; u_dd_v = 0; u_dv_v = 0;
        end
    endtask

    task automatic compare();
        chk("req_ready", {31'h0, req_ready}, {31'h0, m_idle});
        chk("busy", {31'h0, busy}, {31'h0, !m_idle});
        chk("res_valid", {31'h0, res_valid}, {31'h0, m_rv});
        if (m_rv) chk("res_data", res_data, m_rd);
        chk("s_dividend_tvalid", {31'h0, s_dividend_tvalid}, {31'h0, m_dd_need &&  m_sg});
        chk("u_dividend_tvalid", {31'h0, u_dividend_tvalid}, {31'h0, m_dd_need && !m_sg});
        chk("s_divisor_tvalid",  {31'h0, s_divisor_tvalid},  {31'h0, m_dv_need &&  m_sg});
        chk("u_divisor_tvalid",  {31'h0, u_divisor_tvalid},  {31'h0, m_dv_need && !m_sg});
        if (m_dd_need) chk("dividend_tdata", div_dividend_tdata, m_a);
        if (m_dv_need) chk("divisor_tdata", div_divisor_tdata, m_b);
        if (res_valid) rv_cnt++;
        if (s_dividend_tvalid || s_divisor_tvalid) s_tv_cnt++;
        if (s_dividend_tvalid || u_dividend_tvalid) dd_tv_cnt++;
        if (s_divisor_tvalid || u_divisor_tvalid) dv_tv_cnt++;
    endtask

    task automatic model_step();
        logic pre_idle, pre_rv, waiting, dd_hs, dv_hs, sel_dout;
        pre_idle = m_idle;
        pre_rv   = m_rv;
        waiting  = !m_idle && !m_rv && !m_dd_need && !m_dv_need;
        dd_hs    = m_dd_need && dd_tready;
        dv_hs    = m_dv_need && dv_tready;
        sel_dout = m_sg ? s_dout_tvalid : u_dout_tvalid;
        if (flush && !pre_idle) begin
            if (pre_rv) begin
                m_rv = 0; m_idle = 1;
            end else if (m_dd_need && m_dv_need && !dd_hs && !dv_hs) begin
                m_dd_need = 0; m_dv_need = 0; m_idle = 1;
            end else begin
                m_cancel = 1;
            end
        end
        if (!m_idle) begin
            if (dd_hs) m_dd_need = 0;
            if (dv_hs) m_dv_need = 0;
        end
        if (waiting && sel_dout) begin
            if (m_cancel) m_idle = 1;
            else begin m_rv = 1; m_rd = div_ref(m_sg, m_md, m_a, m_b); end
        end
        if (pre_rv && res_ready && !flush) begin m_rv = 0; m_idle = 1; end
        if (pre_idle && req_valid && !flush) begin
            m_idle = 0; m_sg = req_signed; m_md = req_mod; m_a = req_src1; m_b = req_src2;
            m_dd_need = 1; m_dv_need = 1; m_cancel = 0;
            m_acc_cnt++;
        end
    endtask

    // Compare process: every cycle, mid-period, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            ip_drive();
            if (reset) begin
                m_idle = 1; m_rv = 0; m_cancel = 0; m_dd_need = 0; m_dv_need = 0;
            end else begin
                compare();
                ip_collect();
                model_step();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sg, input logic md, input logic [31:0] a,
                        input logic [31:0] b, output int k);
        int base;
        base = m_acc_cnt;
        req_valid = 1; req_signed = sg; req_mod = md; req_src1 = a; req_src2 = b;
        k = 0;
        while (m_acc_cnt == base && k < 100) begin cyc(); k++; end
        req_valid = 0;
        chk("accept_within_budget", {31'h0, m_acc_cnt != base}, 32'h1);
    endtask

    task automatic wait_rv(input int start, output int n);
        n = start;
        while (!res_valid && n < start + 200) begin cyc(); n++; end
        chk("res_valid_within_budget", {31'h0, res_valid}, 32'h1);
    endtask

    task automatic consume();
        res_ready = 1; cyc(); res_ready = 0;
        chk("idle_after_consume", {31'h0, req_ready}, 32'h1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_res_valid"}, {31'h0, res_valid}, 32'h0);
        chk({tag, "_res_data"}, res_data, 32'h0);
        chk({tag, "_tvalids"}, {28'h0, s_dividend_tvalid, s_divisor_tvalid,
                                u_dividend_tvalid, u_divisor_tvalid}, 32'h0);
        chk({tag, "_dividend_tdata"}, div_dividend_tdata, 32'h0);
        chk({tag, "_divisor_tdata"}, div_divisor_tdata, 32'h0);
    endtask

    initial begin
        int k, n, snap, snap2;
        repeat (2) cyc();
        chk_reset_values("reset");
        reset = 0;
        cyc();

        // Signed quotient and remainder of -7 / 2, held until consumed.
        send(1, 0, 32'hFFFFFFF9, 32'h2, k);
        wait_rv(1, n);
        chk("sq_latency", n, 3 + IP_LAT);
        chk("sq_value", res_data, 32'hFFFFFFFD);
        repeat (3) cyc();
        chk("sq_held", {31'h0, res_valid}, 32'h1);
        consume();
        send(1, 1, 32'hFFFFFFF9, 32'h2, k);
        wait_rv(1, n);
        chk("sm_value", res_data, 32'hFFFFFFFF);
        consume();

        // Unsigned remainder: the signed unit is never touched.
        snap = s_tv_cnt;
        send(0, 1, 32'hFFFFFFFF, 32'd10, k);
        wait_rv(1, n);
        chk("ur_value", res_data, 32'h00000005);
        chk("ur_no_s_tvalid", s_tv_cnt - snap, 0);
        consume();

        // Staggered tready: divisor held off for 4 cycles after the dividend lands.
        snap = dd_tv_cnt; snap2 = dv_tv_cnt;
        dv_tready = 0;
        send(0, 0, 32'd1000, 32'd33, k);
        repeat (4) cyc();
        dv_tready = 1;
        wait_rv(5, n);
        chk("stag_dd_cycles", dd_tv_cnt - snap, 1);
        chk("stag_dv_cycles", dv_tv_cnt - snap2, 5);
        chk("stag_latency", n, 7 + IP_LAT);
        chk("stag_value", res_data, 32'h0000001E);
        consume();

        // Flush in WAIT, next request queued behind the drain.
        snap = rv_cnt;
        send(0, 0, 32'd123, 32'd4, k);
        cyc();
        flush = 1; cyc(); flush = 0;
        send(0, 0, 32'd100, 32'd7, k);
        chk("fw_accept_after_drain", k, 3);
        chk("fw_no_stale_result", rv_cnt - snap, 0);
        wait_rv(1, n);
        chk("fw_value", res_data, 32'h0000000E);
        consume();

        // Flush in ISSUE after only the dividend was taken.
        snap = rv_cnt;
        dv_tready = 0;
        send(1, 0, 32'hFFFFFF9C, 32'd7, k);
        cyc();
        flush = 1; cyc(); flush = 0;
        repeat (2) cyc();
        chk("fi_divisor_still_valid", {31'h0, s_divisor_tvalid}, 32'h1);
        chk("fi_busy", {31'h0, busy}, 32'h1);
        dv_tready = 1;
        k = 0;
        while (!req_ready && k < 50) begin cyc(); k++; end
        chk("fi_back_to_idle", {31'h0, req_ready}, 32'h1);
        chk("fi_drain_cycles", k, 4);
        chk("fi_no_result", rv_cnt - snap, 0);

        // Flush while the result is presented.
        send(0, 1, 32'd50, 32'd7, k);
        wait_rv(1, n);
        chk("fd_value", res_data, 32'h00000001);
        flush = 1; cyc(); flush = 0;
        chk("fd_res_valid_dropped", {31'h0, res_valid}, 32'h0);
        chk("fd_idle", {31'h0, req_ready}, 32'h1);

        // Stray results from the unselected or idle unit are ignored.
        stray_u = 1; cyc(); stray_u = 0;
        chk("stray_idle_busy", {31'h0, busy}, 32'h0);
        send(1, 1, 32'd17, 32'd5, k);
        cyc();
        stray_u = 1; cyc(); stray_u = 0;
        wait_rv(3, n);
        chk("stray_wait_latency", n, 3 + IP_LAT);
        chk("stray_wait_value", res_data, 32'h00000002);
        consume();

        // Backpressure in DONE, then reset mid-WAIT.
        send(0, 0, 32'h80000000, 32'd3, k);
        wait_rv(1, n);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_data_stable", res_data, 32'h2AAAAAAA);
            chk("bp_valid_held", {31'h0, res_valid}, 32'h1);
        end
        consume();
        send(1, 0, 32'd100, 32'hFFFFFFFD, k);
        cyc();
        chk("pre_reset_busy", {31'h0, busy}, 32'h1);
        reset = 1;
        #1;
        chk_reset_values("async_reset");
        repeat (2) cyc();
        reset = 0;
        cyc();
        chk("post_reset_ready", {31'h0, req_ready}, 32'h1);
        send(1, 0, 32'd100, 32'hFFFFFFFD, k);
        wait_rv(1, n);
        chk("post_reset_value", res_data, 32'hFFFFFFDF);
        consume();

        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequencer between the EX stage and the two pipelined divider IPs (signed and unsigned). It accepts one divide/modulo request at a time, latches its operands, and completes the AXI-stream handshake on the dividend and divisor channels independently, issuing exactly once per request. It then waits for the result, selects quotient or remainder, and holds it until EX consumes it. On a pipeline flush it cancels cleanly, draining any in-flight IP result so a stale result can never be attributed to a later instruction.

## Interface

- Parameters: none; data width fixed at 32, divider output at 64 (quotient [63:32], remainder [31:0]).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  EX holds a valid div/mod instruction.
- `req_signed`  in  1  1: div.w/mod.w, 0: div.wu/mod.wu.
- `req_mod`  in  1  1: remainder, 0: quotient.
- `req_src1` / `req_src2`  in  32  dividend / divisor.
- `req_ready`  out  1  high only in IDLE.
- `flush`  in  1  cancel current operation (exception/ertn).
- `res_valid`  out  1  result available (drives EX ready_go).
- `res_data`  out  32  selected quotient/remainder.
- `res_ready`  in  1  EX moving to MEM this cycle.
- `busy`  out  1  state != IDLE.
- `s_dividend_tvalid`, `s_divisor_tvalid`, `u_dividend_tvalid`, `u_divisor_tvalid`  out  1 each.
- `s_dividend_tready`, `s_divisor_tready`, `u_dividend_tready`, `u_divisor_tready`  in  1 each.
- `div_dividend_tdata` / `div_divisor_tdata`  out  32  latched operands, shared by both IPs.
- `s_dout_tvalid`, `u_dout_tvalid`  in  1; `s_dout_tdata`, `u_dout_tdata`  in  64.

## Operation

- States: IDLE, ISSUE, WAIT, DONE, DRAIN.
- Accept = `req_valid & req_ready & ~flush`. On accept, latch src1, src2, signed, mod; clear per-channel accepted flags `dd_acc`, `dv_acc`; go to ISSUE.
- ISSUE: only the selected unit's tvalids may assert. Dividend tvalid = ~dd_acc; divisor tvalid = ~dv_acc. A channel sets its flag on tvalid & tready. Each tvalid drops the cycle after its own handshake. When both are accepted (or the last one completes this cycle), go to WAIT.
- WAIT: on the selected unit's dout_tvalid, capture `res_data` = mod ? dout[31:0] : dout[63:32] and go to DONE. The other unit's dout_tvalid is ignored.
- DONE: `res_valid`=1 and `res_data` stable. On `res_ready`, go to IDLE.
- Flush by state:
  - IDLE: no accept.
  - ISSUE with neither flag set: go to IDLE, tvalids drop next cycle.
  - ISSUE with one flag set: keep issuing the remaining channel, then go to DRAIN (the IP must not hold a half operand pair).
  - WAIT: go to DRAIN.
  - DONE: go to IDLE, `res_valid` drops.
- DRAIN: wait for the selected dout_tvalid, discard it, go to IDLE. `res_valid` stays 0. Further flushes have no effect.
- A dout_tvalid arriving in IDLE or ISSUE is ignored.
- Divide by zero is not special-cased; the IP output is passed through.
- Reset values: state IDLE; all tvalids 0; `res_valid` 0; `res_data` 0; tdata 0; `busy` 0; `req_ready` 1.
- Reset asserted mid-operation returns to IDLE immediately. The IP is reset by the same signal.

## Timing

- All outputs are registered or decoded from registered state; no input-to-output combinational path except `req_ready`/`busy` from state.
- Accept at cycle N: tvalid(s) high at N+1.
- With tready=1, both channels handshake at N+1 and state=WAIT at N+2.
- dout_tvalid at cycle M: `res_valid`=1 at M+1.
- `res_valid & res_ready` at cycle K: IDLE and `req_ready`=1 at K+1. The earliest next accept is K+1.
- Total from accept to `res_valid` = 3 + IP latency cycles.

## Test plan

- Signed quotient: src1=0xFFFFFFF9 (-7), src2=2, signed, mod=0. Requires `res_data`=0xFFFFFFFD, `res_valid` 1 until `res_ready`. Mod=1 gives 0xFFFFFFFF.
- Unsigned remainder: src1=0xFFFFFFFF, src2=10, mod=1. Requires 0x00000005, with no s_* tvalid ever high.
- Staggered tready: divisor tready low for 4 cycles after dividend accepts. Dividend tvalid must be high for exactly 1 cycle, divisor tvalid for 5. WAIT is entered only after both handshakes.
- Flush in WAIT, then a new request 100/7 unsigned quotient. The drained result is not presented. The new request is accepted only after the drain. `res_data`=0x0000000E.
- Flush in ISSUE with dividend accepted and divisor tready held low. Divisor tvalid must remain high until accepted, then DRAIN, then IDLE. `res_valid` never rises.
- Backpressure and reset: hold `res_ready`=0 for 10 cycles in DONE; `res_data` stays stable. Assert `reset` mid-WAIT. Outputs return to reset values asynchronously and `req_ready`=1.
